// File: rtl/gpio_input_mirror.sv
// GPIO input mirror: synchronizes and debounces the GPI pads, mirrors the
// accepted value (optionally inverted) onto the GPO pads, counts accepted
// changes and offers a single-beat read handshake to the management side.
module gpio_input_mirror #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] gpi,
  input  logic             enable,
  input  logic [WIDTH-1:0] invert,
  output logic [WIDTH-1:0] gpo,
  output logic [WIDTH-1:0] gpo_oeb,
  output logic             change_irq,
  input  logic             clr_count,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [15:0]      rd_data
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CCNT_W  = 8;
  localparam int unsigned RD_BITS = (WIDTH < 8) ? WIDTH : 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ACK  = 2'd1,
    RD_WAIT = 2'd2
  } rd_state_t;

  logic [WIDTH-1:0]  s1;
  logic [WIDTH-1:0]  s2;
  logic [WIDTH-1:0]  cand;
  logic [WIDTH-1:0]  stable;
  logic [CNT_W-1:0]  cnt;
  logic [CCNT_W-1:0] change_count;
  logic [7:0]        stable_b;
  logic              accept_c;
  logic              rd_armed;
  logic              ack_nxt;
  rd_state_t         state;
  rd_state_t         state_nxt;

  // Two-flop synchronizer, free-running regardless of enable
  always_ff @(posedge clock) begin
    if (!resetb) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= gpi;
      s2 <= s1;
    end
  end

  // Candidate held for the full debounce window and different from stable
  assign accept_c = enable && (s2 == cand) && (cnt >= CNT_MAX) && (cand != stable);

  // Whole-word debounce; while disabled the candidate tracks s2 so counting
  // restarts cleanly from zero on re-enable
  always_ff @(posedge clock) begin
    if (!resetb) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else if (!enable) begin
      cand <= s2;
      cnt  <= '0;
    end else if (s2 != cand) begin
      cand <= s2;
      cnt  <= '0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end else if (accept_c) begin
      stable <= cand;
    end
  end

  // Change counter, change interrupt and pad output enable
  always_ff @(posedge clock) begin
    if (!resetb) begin
      change_count <= '0;
      change_irq   <= 1'b0;
      gpo_oeb      <= '1;
    end else begin
      change_irq <= accept_c;
      gpo_oeb    <= {WIDTH{~enable}};
      if (clr_count) begin
        change_count <= accept_c ? CCNT_W'(1) : CCNT_W'(0);
      end else if (accept_c) begin
        change_count <= change_count + CCNT_W'(1);
      end
    end
  end

  assign gpo = stable ^ invert;

  // Stable value fitted to the 8-bit read field
  always_comb begin
    stable_b = '0;
    for (int unsigned i = 0; i < RD_BITS; i++) begin
      stable_b[i] = stable[i];
    end
  end

  // A request held across reset must be seen low before it can be served
  always_ff @(posedge clock) begin
    if (!resetb) begin
      rd_armed <= ~rd_req;
    end else if (!rd_req) begin
      rd_armed <= 1'b1;
    end
  end

  // Read FSM state register
  always_ff @(posedge clock) begin
    if (!resetb) begin
      state <= RD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE: if (rd_req && rd_armed) state_nxt = RD_ACK;
      RD_ACK:  state_nxt = RD_WAIT;
      RD_WAIT: if (!rd_req) state_nxt = RD_IDLE;
      default: state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM output decode
  always_comb begin
    ack_nxt = 1'b0;
    if (state == RD_ACK) begin
      ack_nxt = 1'b1;
    end
  end

  // Registered acknowledge and snapshot of the pre-edge count and stable value
  always_ff @(posedge clock) begin
    if (!resetb) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= ack_nxt;
      if (ack_nxt) begin
        rd_data <= {change_count, stable_b};
      end
    end
  end

endmodule

// File: tb/tb_gpio_input_mirror.sv
// Self-checking bench for gpio_input_mirror: directed vector table, hand
// sequences for multi-cycle corners, and random stimulus against a
// window-based reference model.
module tb_gpio_input_mirror;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEB   = 4;

  logic             clock;
  logic             resetb;
  logic [WIDTH-1:0] gpi;
  logic             enable;
  logic [WIDTH-1:0] invert;
  logic [WIDTH-1:0] gpo;
  logic [WIDTH-1:0] gpo_oeb;
  logic             change_irq;
  logic             clr_count;
  logic             rd_req;
  logic             rd_ack;
  logic [15:0]      rd_data;

  gpio_input_mirror #(.WIDTH(WIDTH), .DEBOUNCE(DEB)) dut (
    .clock      (clock),
    .resetb     (resetb),
    .gpi        (gpi),
    .enable     (enable),
    .invert     (invert),
    .gpo        (gpo),
    .gpo_oeb    (gpo_oeb),
    .change_irq (change_irq),
    .clr_count  (clr_count),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int irq_seen = 0;
  int ack_seen = 0;

  // Reference model: acceptance is judged from a window of the last DEB+1
  // synchronized samples and the enable history
  logic [7:0]  g1, g2;
  logic [7:0]  s_win [DEB+1];
  logic        en_win [DEB+1];
  logic [7:0]  m_stable, m_count, m_oeb;
  logic        m_irq, m_ack, m_ready, m_sched;
  logic [15:0] m_rd_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [7:0] s_now;
    logic [7:0] old_st;
    logic [7:0] old_cnt;
    logic       all_eq;
    logic       all_en;
    logic       acc;
    if (!resetb) begin
      g1 = '0;
      g2 = '0;
      for (int i = 0; i <= DEB; i++) begin
        s_win[i]  = '0;
        en_win[i] = 1'b0;
      end
      m_stable  = '0;
      m_count   = '0;
      m_oeb     = '1;
      m_irq     = 1'b0;
      m_ack     = 1'b0;
      m_sched   = 1'b0;
      m_rd_data = '0;
      m_ready   = !rd_req;
    end else begin
      s_now = g2;
      g2 = g1;
      g1 = gpi;
      for (int i = DEB; i > 0; i--) begin
        s_win[i]  = s_win[i-1];
        en_win[i] = en_win[i-1];
      end
      s_win[0]  = s_now;
      en_win[0] = enable;
      all_eq = 1'b1;
      for (int i = 0; i <= DEB; i++) if (s_win[i] != s_now) all_eq = 1'b0;
      all_en = 1'b1;
      for (int i = 0; i < DEB; i++) if (!en_win[i]) all_en = 1'b0;
      acc = all_eq && all_en && (s_now != m_stable);
      old_st  = m_stable;
      old_cnt = m_count;
      if (m_sched) begin
        m_ack     = 1'b1;
        m_rd_data = {old_cnt, old_st};
        m_sched   = 1'b0;
      end else begin
        m_ack = 1'b0;
        if (!rd_req) m_ready = 1'b1;
        else if (m_ready) begin
          m_sched = 1'b1;
          m_ready = 1'b0;
        end
      end
      if (acc) m_stable = s_now;
      m_irq = acc;
      if (clr_count) m_count = acc ? 8'd1 : 8'd0;
      else if (acc) m_count = m_count + 8'd1;
      m_oeb = enable ? 8'h00 : 8'hFF;
    end
  endtask

  // One clock: model follows the rising edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    if (change_irq === 1'b1) irq_seen++;
    if (rd_ack === 1'b1) ack_seen++;
    chk("model_gpo", gpo, m_stable ^ invert);
    chk("model_oeb", gpo_oeb, m_oeb);
    chk("model_irq", change_irq, m_irq);
    chk("model_ack", rd_ack, m_ack);
    chk("model_rd_data", rd_data, m_rd_data);
  endtask

  task automatic do_read(input string name, input logic [15:0] exp);
    logic got;
    got = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      if (rd_ack === 1'b1) begin
        got = 1'b1;
        chk(name, rd_data, exp);
      end
    end
    chk({name, "_ack_seen"}, got, 1'b1);
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  typedef struct {
    logic [7:0] gpi;
    logic       en;
    logic [7:0] inv;
    int         ticks;
    logic [7:0] e_gpo;
    logic [7:0] e_oeb;
    logic       e_irq;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hold;
    tbl[0] = '{8'hAA, 1'b1, 8'h00, 1, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{8'hAA, 1'b1, 8'h00, 5, 8'h00, 8'h00, 1'b0};
    tbl[2] = '{8'hAA, 1'b1, 8'h00, 1, 8'hAA, 8'h00, 1'b1};
    tbl[3] = '{8'hAA, 1'b1, 8'h00, 1, 8'hAA, 8'h00, 1'b0};
    tbl[4] = '{8'h55, 1'b1, 8'h00, 3, 8'hAA, 8'h00, 1'b0};
    tbl[5] = '{8'hAA, 1'b1, 8'h00, 8, 8'hAA, 8'h00, 1'b0};
    tbl[6] = '{8'hAA, 1'b1, 8'hFF, 0, 8'h55, 8'h00, 1'b0};
    tbl[7] = '{8'hAA, 1'b0, 8'hFF, 0, 8'h55, 8'h00, 1'b0};
    tbl[8] = '{8'hAA, 1'b0, 8'hFF, 1, 8'h55, 8'hFF, 1'b0};

    resetb = 1'b0; gpi = '0; enable = 1'b0; invert = '0; clr_count = 1'b0; rd_req = 1'b0;
    tick();
    tick();
    chk("reset_gpo", gpo, 8'h00);
    chk("reset_oeb", gpo_oeb, 8'hFF);
    chk("reset_irq", change_irq, 1'b0);
    chk("reset_ack", rd_ack, 1'b0);
    chk("reset_rd_data", rd_data, 16'h0000);

    // Directed vectors: latency, glitch rejection, inversion, disable
    resetb = 1'b1;
    irq_seen = 0;
    for (int r = 0; r < 9; r++) begin
      gpi = tbl[r].gpi;
      enable = tbl[r].en;
      invert = tbl[r].inv;
      if (tbl[r].ticks == 0) #1;
      else repeat (tbl[r].ticks) tick();
      chk($sformatf("row%0d_gpo", r), gpo, tbl[r].e_gpo);
      chk($sformatf("row%0d_oeb", r), gpo_oeb, tbl[r].e_oeb);
      chk($sformatf("row%0d_irq", r), change_irq, tbl[r].e_irq);
    end
    chk("first_change_irq_pulses", irq_seen, 1);

    // Two more changes give count 3 with stable 8'hAA, then a long request
    enable = 1'b1; invert = 8'h00;
    @(negedge clock);
    gpi = 8'h55; repeat (8) tick();
    gpi = 8'hAA; repeat (8) tick();
    ack_seen = 0;
    rd_req = 1'b1;
    tick();
    chk("read_latency_early", rd_ack, 1'b0);
    tick();
    chk("read_latency_ack", rd_ack, 1'b1);
    chk("read_data_03AA", rd_data, 16'h03AA);
    repeat (8) tick();
    chk("read_single_ack", ack_seen, 1);
    rd_req = 1'b0; tick();
    rd_req = 1'b1; tick(); tick();
    chk("read_second_ack", rd_ack, 1'b1);
    chk("read_second_data", rd_data, 16'h03AA);
    rd_req = 1'b0; tick(); tick();

    // 256 accepted changes wrap the count back to zero
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    irq_seen = 0;
    for (int k = 0; k < 256; k++) begin
      gpi = ~gpi;
      repeat (7) tick();
    end
    chk("wrap_irq_pulses", irq_seen, 256);
    do_read("wrap_read", 16'h00AA);

    // Clear coincident with an accepted change leaves count at one
    gpi = 8'h55;
    repeat (6) tick();
    clr_count = 1'b1;
    tick();
    chk("clr_coincident_irq", change_irq, 1'b1);
    clr_count = 1'b0;
    do_read("clr_coincident_read", 16'h0155);

    // Reset during WAIT and mid-debounce, with the request held across it
    rd_req = 1'b1;
    tick(); tick(); tick();
    gpi = 8'hAA;
    repeat (3) tick();
    resetb = 1'b0; invert = 8'h0F;
    tick();
    chk("midreset_gpo", gpo, 8'h0F);
    chk("midreset_oeb", gpo_oeb, 8'hFF);
    chk("midreset_irq", change_irq, 1'b0);
    chk("midreset_ack", rd_ack, 1'b0);
    chk("midreset_rd_data", rd_data, 16'h0000);
    resetb = 1'b1;
    ack_seen = 0;
    repeat (6) tick();
    chk("held_req_no_ack", ack_seen, 0);
    rd_req = 1'b0; tick();
    rd_req = 1'b1; tick(); tick();
    chk("rearmed_ack", rd_ack, 1'b1);
    rd_req = 1'b0; tick();

    // Random stimulus against the reference model
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        gpi = 8'($urandom);
        hold = $urandom_range(1, 10);
      end
      hold--;
      if (enable) begin
        if ($urandom_range(0, 39) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 7) == 0) enable = 1'b1;
      if ($urandom_range(0, 19) == 0) invert = 8'($urandom);
      clr_count = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 4) == 0) rd_req = ~rd_req;
      resetb = !($urandom_range(0, 299) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
